// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  localparam int unsigned DEFAULT_PAYLOAD_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRIG      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } arb_state_e;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (x < v) begin
        x = x << 1;
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// ptr_i+1 with wrap, returned as one-hot grant plus binary index.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int unsigned cand;
  logic        found;

  // Scan the NUM_REQ positions after ptr_i; the pointer itself is checked last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grant, latch
// the byte, pulse the trigger, then follow busy/done (or time out) back to idle.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_data,
  output logic [NUM_REQ-1:0]              o_ack,
  output logic [NUM_REQ-1:0]              o_done,
  output logic                            o_err,
  output logic [clog2(NUM_REQ)-1:0]       o_grant_id,
  output logic                            o_busy,
  output logic                            o_tx_trig,
  output logic [PAYLOAD_BITS-1:0]         o_tx_data,
  input  logic                            i_tx_busy,
  input  logic                            i_tx_done
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         gid_q, gid_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     trig_q, trig_d;
  logic [PAYLOAD_BITS-1:0]  data_q, data_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     txbusy_prev_q;

  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;
  logic                     tx_busy_fall;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign tx_busy_fall = txbusy_prev_q & ~i_tx_busy;

  // Next-state and registered-output logic; pulses default low every clock.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    trig_d  = 1'b0;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          ack_d   = arb_gnt;
          data_d  = i_data[32'(arb_idx) * PAYLOAD_BITS +: PAYLOAD_BITS];
          gid_d   = arb_idx;
          ptr_d   = arb_idx;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        trig_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // done and busy-fall in the same clock collapse into one o_done
        if (i_tx_done || tx_busy_fall) begin
          done_d[gid_q] = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_RST;
      gid_q         <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      trig_q        <= 1'b0;
      data_q        <= '0;
      cnt_q         <= '0;
      txbusy_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gid_q         <= gid_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      trig_q        <= trig_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      txbusy_prev_q <= i_tx_busy;
    end
  end

  assign o_ack      = ack_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_grant_id = gid_q;
  assign o_busy     = busy_q;
  assign o_tx_trig  = trig_q;
  assign o_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scripted uart_tx stub (busy/done).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  i_req;
  logic [23:0] i_data;
  logic [2:0]  o_ack;
  logic [2:0]  o_done;
  logic        o_err;
  logic [1:0]  o_grant_id;
  logic        o_busy;
  logic        o_tx_trig;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic        i_tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (3),
    .PAYLOAD_BITS (8),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_tx_trig  (o_tx_trig),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .i_tx_done  (i_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"},  32'(o_ack), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"},  32'(o_err), 32'd0);
    check({tag, "_gid"},  32'(o_grant_id), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_trig"}, 32'(o_tx_trig), 32'd0);
    check({tag, "_data"}, 32'(o_tx_data), 32'd0);
  endtask

  // Called on the negedge where the request is (already) presented; returns on the ack negedge.
  task automatic expect_grant(input int k, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (o_ack == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", 32'(n), 32'd0);
    check("ack_onehot", 32'(o_ack), 32'(1) << k);
    check("ack_gid", 32'(o_grant_id), 32'(k));
    check("ack_data", 32'(o_tx_data), 32'(b));
    check("ack_no_done", 32'(o_done), 32'd0);
    check("ack_busy", 32'(o_busy), 32'd1);
    check("ack_no_trig", 32'(o_tx_trig), 32'd0);
  endtask

  // Stub uart_tx run from the ack negedge. mode 0: busy falls; 1: done + busy fall; 2: done only.
  task automatic complete_frame(input int k, input logic [7:0] b, input int mode,
                                input logic [2:0] req_mid);
    @(negedge clk);
    check("trig_pulse", 32'(o_tx_trig), 32'd1);
    check("trig_no_ack", 32'(o_ack), 32'd0);
    i_tx_busy = 1'b1;
    @(negedge clk);
    check("trig_single", 32'(o_tx_trig), 32'd0);
    check("inflight_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    i_req = req_mid;
    @(negedge clk);
    check("hold_data", 32'(o_tx_data), 32'(b));
    check("hold_gid", 32'(o_grant_id), 32'(k));
    check("hold_no_done", 32'(o_done), 32'd0);
    case (mode)
      0: i_tx_busy = 1'b0;
      1: begin i_tx_busy = 1'b0; i_tx_done = 1'b1; end
      default: i_tx_done = 1'b1;
    endcase
    @(negedge clk);
    check("done_onehot", 32'(o_done), 32'(1) << k);
    check("done_idle", 32'(o_busy), 32'd0);
    check("done_no_ack", 32'(o_ack), 32'd0);
    i_tx_done = 1'b0;
    i_tx_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b1;
    i_req     = 3'b000;
    i_data    = 24'h000000;
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    #2 reset_n = 1'b0;
    tick(2);
    check_reset_vals("reset");
    reset_n = 1'b1;

    // Single request from requester 0
    tick(1);
    i_req  = 3'b001;
    i_data = 24'h0000ab;
    expect_grant(0, 8'hab);
    i_req = 3'b000;
    complete_frame(0, 8'hab, 1, 3'b000);
    tick(1);
    check("single_done_once", 32'(o_done), 32'd0);
    check("single_busy_low", 32'(o_busy), 32'd0);
    check("single_no_ack", 32'(o_ack), 32'd0);

    // Contention from a fresh reset: order 0,1,2
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    i_data  = 24'hefcdab;
    i_req   = 3'b111;
    expect_grant(0, 8'hab);
    i_req = 3'b110;
    complete_frame(0, 8'hab, 0, 3'b110);
    expect_grant(1, 8'hcd);
    i_req = 3'b100;
    complete_frame(1, 8'hcd, 0, 3'b100);
    expect_grant(2, 8'hef);
    i_req = 3'b000;
    complete_frame(2, 8'hef, 0, 3'b000);

    // Fairness: requester 0 holds, requester 2 requests once -> 0,2,0,0
    i_req = 3'b001;
    expect_grant(0, 8'hab);
    i_req = 3'b101;
    complete_frame(0, 8'hab, 0, 3'b101);
    expect_grant(2, 8'hef);
    i_req = 3'b001;
    complete_frame(2, 8'hef, 1, 3'b001);
    expect_grant(0, 8'hab);
    complete_frame(0, 8'hab, 0, 3'b001);
    expect_grant(0, 8'hab);
    i_req = 3'b000;
    complete_frame(0, 8'hab, 0, 3'b000);

    // Withdraw: requester 1 raises then drops while requester 0 is in flight
    i_req = 3'b001;
    expect_grant(0, 8'hab);
    i_req = 3'b010;
    complete_frame(0, 8'hab, 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("withdraw_no_ack", 32'(o_ack), 32'd0);
      check("withdraw_idle", 32'(o_busy), 32'd0);
    end

    // Timeout: busy never rises
    i_req = 3'b001;
    expect_grant(0, 8'hab);
    i_req = 3'b000;
    tick(1);
    check("to_trig", 32'(o_tx_trig), 32'd1);
    tick(15);
    check("to_not_early", 32'(o_err), 32'd0);
    check("to_still_busy", 32'(o_busy), 32'd1);
    tick(1);
    check("to_err", 32'(o_err), 32'd1);
    check("to_no_done", 32'(o_done), 32'd0);
    check("to_idle", 32'(o_busy), 32'd0);
    tick(1);
    check("to_err_single", 32'(o_err), 32'd0);
    i_tx_done = 1'b1;
    tick(1);
    check("idle_done_ignored", 32'(o_done), 32'd0);
    check("idle_done_no_busy", 32'(o_busy), 32'd0);
    i_tx_done = 1'b0;
    i_req     = 3'b010;
    expect_grant(1, 8'hcd);
    i_req = 3'b000;
    complete_frame(1, 8'hcd, 2, 3'b000);

    // Reset in WAIT_DONE, then a clean frame from requester 1
    i_req = 3'b100;
    expect_grant(2, 8'hef);
    i_req = 3'b000;
    tick(1);
    check("mid_trig", 32'(o_tx_trig), 32'd1);
    i_tx_busy = 1'b1;
    tick(2);
    check("mid_busy", 32'(o_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_async");
    tick(1);
    check_reset_vals("mid_held");
    i_tx_busy = 1'b0;
    reset_n   = 1'b1;
    i_req     = 3'b010;
    expect_grant(1, 8'hcd);
    i_req = 3'b000;
    complete_frame(1, 8'hcd, 1, 3'b000);
    tick(1);
    check("final_done_once", 32'(o_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
